// File: rtl/mem_lsu_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, lw/sw load/store unit
// on a req/ack bus with timeout and misalign detection, and the MEM/WB register.
module mem_lsu_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [31:0]       ex_alu_res,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_wraddr,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_regwrite,
  output logic              stall_req,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              mem_regwrite,
  output logic [4:0]        mem_wraddr,
  output logic              mem_memread,
  output logic [31:0]       mem_fwd_data,
  output logic              wb_regwrite,
  output logic [4:0]        wb_wraddr,
  output logic [31:0]       wb_data,
  output logic              misalign,
  output logic              bus_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               mv_q, mv_d;
  logic [31:0]        malu_q, malu_d;
  logic [4:0]         mwraddr_q, mwraddr_d;
  logic               mrd_q, mrd_d;
  logic               mm2r_q, mm2r_d;
  logic               mrw_q, mrw_d;

  logic               dm_req_q, dm_req_d;
  logic               dm_we_q, dm_we_d;
  logic [ADDR_W-1:0]  dm_addr_q, dm_addr_d;
  logic [31:0]        dm_wdata_q, dm_wdata_d;

  logic               wb_regwrite_q, wb_regwrite_d;
  logic [4:0]         wb_wraddr_q, wb_wraddr_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               misalign_q, misalign_d;
  logic               bus_err_q, bus_err_d;

  logic               busy;
  logic               timeout_hit;
  logic               stall;
  logic               ex_mem;
  logic               ex_mis;
  logic               ex_start;
  logic [ADDR_W-1:0]  ex_addr;

  assign busy        = (state_q == BUSY);
  assign timeout_hit = busy & ~dm_ack & (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign stall       = busy & ~dm_ack & ~timeout_hit;

  assign ex_mem   = ex_valid & (ex_memread | ex_memwrite);
  assign ex_mis   = ex_mem & (ex_alu_res[1:0] != 2'b00);
  assign ex_start = ex_mem & ~ex_mis;
  assign ex_addr  = ADDR_W'(ex_alu_res);

  // Every non-stalled edge retires the MEM instruction and captures the next one;
  // a misaligned access or a timed-out access retires as a bubble.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mv_d          = mv_q;
    malu_d        = malu_q;
    mwraddr_d     = mwraddr_q;
    mrd_d         = mrd_q;
    mm2r_d        = mm2r_q;
    mrw_d         = mrw_q;
    dm_req_d      = dm_req_q;
    dm_we_d       = dm_we_q;
    dm_addr_d     = dm_addr_q;
    dm_wdata_d    = dm_wdata_q;
    wb_regwrite_d = 1'b0;
    wb_wraddr_d   = wb_wraddr_q;
    wb_data_d     = wb_data_q;
    misalign_d    = 1'b0;
    bus_err_d     = 1'b0;

    if (stall) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      wb_regwrite_d = mv_q & mrw_q & ~misalign_q & ~timeout_hit;
      wb_wraddr_d   = mwraddr_q;
      wb_data_d     = mm2r_q ? dm_rdata : malu_q;
      bus_err_d     = timeout_hit;

      mv_d      = ex_valid;
      malu_d    = ex_alu_res;
      mwraddr_d = ex_wraddr;
      mrd_d     = ex_memread;
      mm2r_d    = ex_memtoreg;
      // A store never writes the RF, whatever regwrite EX sends along with it.
      mrw_d     = ex_regwrite & ~ex_memwrite;

      misalign_d = ex_mis;
      state_d    = ex_start ? BUSY : IDLE;
      cnt_d      = 16'd0;
      dm_req_d   = ex_start;
      if (ex_start) begin
        dm_we_d    = ex_memwrite;
        dm_addr_d  = {ex_addr[ADDR_W-1:2], 2'b00};
        dm_wdata_d = ex_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mv_q          <= 1'b0;
      malu_q        <= '0;
      mwraddr_q     <= '0;
      mrd_q         <= 1'b0;
      mm2r_q        <= 1'b0;
      mrw_q         <= 1'b0;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_wdata_q    <= '0;
      wb_regwrite_q <= 1'b0;
      wb_wraddr_q   <= '0;
      wb_data_q     <= '0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mv_q          <= mv_d;
      malu_q        <= malu_d;
      mwraddr_q     <= mwraddr_d;
      mrd_q         <= mrd_d;
      mm2r_q        <= mm2r_d;
      mrw_q         <= mrw_d;
      dm_req_q      <= dm_req_d;
      dm_we_q       <= dm_we_d;
      dm_addr_q     <= dm_addr_d;
      dm_wdata_q    <= dm_wdata_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_wraddr_q   <= wb_wraddr_d;
      wb_data_q     <= wb_data_d;
      misalign_q    <= misalign_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign stall_req    = stall;
  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_wdata     = dm_wdata_q;
  assign mem_regwrite = mv_q & mrw_q & ~mrd_q;
  assign mem_wraddr   = mwraddr_q;
  assign mem_memread  = mv_q & mrd_q;
  assign mem_fwd_data = malu_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_wraddr    = wb_wraddr_q;
  assign wb_data      = wb_data_q;
  assign misalign     = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Bench for mem_lsu_stage: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_lsu_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [31:0] ex_alu_res, ex_wdata;
  logic [4:0]  ex_wraddr;
  logic        stall_req, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_regwrite, mem_memread, wb_regwrite, misalign, bus_err;
  logic [4:0]  mem_wraddr, wb_wraddr;
  logic [31:0] mem_fwd_data, wb_data;

  int pass_cnt  = 0;
  int check_cnt = 0;

  mem_lsu_stage #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_res(ex_alu_res), .ex_wdata(ex_wdata),
    .ex_wraddr(ex_wraddr), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .stall_req(stall_req), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_regwrite(mem_regwrite), .mem_wraddr(mem_wraddr), .mem_memread(mem_memread),
    .mem_fwd_data(mem_fwd_data), .wb_regwrite(wb_regwrite), .wb_wraddr(wb_wraddr),
    .wb_data(wb_data), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        rd, wr, m2r, rw;
  } instr_t;

  // Model: the instruction sitting in MEM, how long it has been there, and the
  // WB / pulse outputs expected for the current cycle.
  instr_t      slot = '0;
  int          age = 0;
  logic        exp_wb_rw = 1'b0;
  logic [4:0]  exp_wb_wa = '0;
  logic [31:0] exp_wb_d = '0;
  logic        exp_mis = 1'b0;
  logic        exp_berr = 1'b0;

  function automatic logic is_access(instr_t i);
    return i.v && (i.rd || i.wr) && (i.a[1:0] == 2'b00);
  endfunction

  function automatic logic is_misaligned(instr_t i);
    return i.v && (i.rd || i.wr) && (i.a[1:0] != 2'b00);
  endfunction

  function automatic logic model_timed_out();
    return is_access(slot) && (age == TMO - 1) && !dm_ack;
  endfunction

  function automatic logic model_stalled();
    return is_access(slot) && !dm_ack && !model_timed_out();
  endfunction

  function automatic instr_t cur_ex();
    instr_t i;
    i.v = ex_valid; i.a = ex_alu_res; i.wd = ex_wdata; i.wa = ex_wraddr;
    i.rd = ex_memread; i.wr = ex_memwrite; i.m2r = ex_memtoreg; i.rw = ex_regwrite;
    return i;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      slot = '0; age = 0; exp_wb_rw = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0;
    end else if (model_stalled()) begin
      age++;
      exp_wb_rw = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0;
    end else begin
      exp_wb_rw = slot.v && slot.rw && !slot.wr && !is_misaligned(slot) && !model_timed_out();
      if (exp_wb_rw) begin
        exp_wb_wa = slot.wa;
        exp_wb_d  = slot.m2r ? dm_rdata : slot.a;
      end
      exp_berr = model_timed_out();
      exp_mis  = is_misaligned(cur_ex());
      slot     = cur_ex();
      age      = 0;
    end
  end

  always @(negedge clk) begin
    checkOutput("stall_req", 32'(stall_req), 32'(model_stalled()));
    checkOutput("dm_req", 32'(dm_req), 32'(is_access(slot)));
    if (is_access(slot)) begin
      checkOutput("dm_we", 32'(dm_we), 32'(slot.wr));
      checkOutput("dm_addr", dm_addr, slot.a & 32'hFFFF_FFFC);
      if (slot.wr) checkOutput("dm_wdata", dm_wdata, slot.wd);
    end
    checkOutput("mem_regwrite", 32'(mem_regwrite), 32'(slot.v && slot.rw && !slot.rd && !slot.wr));
    checkOutput("mem_memread", 32'(mem_memread), 32'(slot.v && slot.rd));
    if (slot.v) begin
      checkOutput("mem_fwd_data", mem_fwd_data, slot.a);
      checkOutput("mem_wraddr", 32'(mem_wraddr), 32'(slot.wa));
    end
    checkOutput("wb_regwrite", 32'(wb_regwrite), 32'(exp_wb_rw));
    if (exp_wb_rw) begin
      checkOutput("wb_wraddr", 32'(wb_wraddr), 32'(exp_wb_wa));
      checkOutput("wb_data", wb_data, exp_wb_d);
    end
    checkOutput("misalign", 32'(misalign), 32'(exp_mis));
    checkOutput("bus_err", 32'(bus_err), 32'(exp_berr));
  end

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] wd,
                               input logic [4:0] wa, input logic rd, input logic wr,
                               input logic m2r, input logic rw);
    ex_valid = v; ex_alu_res = a; ex_wdata = wd; ex_wraddr = wa;
    ex_memread = rd; ex_memwrite = wr; ex_memtoreg = m2r; ex_regwrite = rw;
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    dm_ack = 1'b0;
    dm_rdata = 32'h0;
    bubble();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset dm_req", 32'(dm_req), 32'h0);
    checkOutput("reset stall_req", 32'(stall_req), 32'h0);
    checkOutput("reset wb_regwrite", 32'(wb_regwrite), 32'h0);
    rst = 1'b0;

    // ALU op: add -> $8 = 0x10
    applyStimulus(1'b1, 32'h10, 32'h0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); bubble(); #1;
    checkOutput("alu mem_regwrite", 32'(mem_regwrite), 32'h1);
    checkOutput("alu mem_fwd_data", mem_fwd_data, 32'h10);
    tick();
    checkOutput("alu wb_regwrite", 32'(wb_regwrite), 32'h1);
    checkOutput("alu wb_wraddr", 32'(wb_wraddr), 32'd8);
    checkOutput("alu wb_data", wb_data, 32'h10);

    // lw, zero-wait
    applyStimulus(1'b1, 32'h100, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); bubble(); dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF; #1;
    checkOutput("lw0 stall_req", 32'(stall_req), 32'h0);
    checkOutput("lw0 dm_req", 32'(dm_req), 32'h1);
    checkOutput("lw0 dm_addr", dm_addr, 32'h100);
    checkOutput("lw0 mem_memread", 32'(mem_memread), 32'h1);
    tick(); dm_ack = 1'b0; #1;
    checkOutput("lw0 wb_regwrite", 32'(wb_regwrite), 32'h1);
    checkOutput("lw0 wb_wraddr", 32'(wb_wraddr), 32'd9);
    checkOutput("lw0 wb_data", wb_data, 32'hDEAD_BEEF);
    checkOutput("lw0 dm_req drop", 32'(dm_req), 32'h0);

    // sw with ack in the third cycle; regwrite set on the sw must be ignored
    applyStimulus(1'b1, 32'h204, 32'h1234_5678, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); applyStimulus(1'b1, 32'h55, 32'h0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    checkOutput("sw dm_req", 32'(dm_req), 32'h1);
    checkOutput("sw dm_we", 32'(dm_we), 32'h1);
    checkOutput("sw dm_addr", dm_addr, 32'h204);
    checkOutput("sw dm_wdata", dm_wdata, 32'h1234_5678);
    checkOutput("sw stall c1", 32'(stall_req), 32'h1);
    tick();
    checkOutput("sw stall c2", 32'(stall_req), 32'h1);
    checkOutput("sw addr held", dm_addr, 32'h204);
    checkOutput("sw fwd held", mem_fwd_data, 32'h204);
    tick(); dm_ack = 1'b1; #1;
    checkOutput("sw stall c3", 32'(stall_req), 32'h0);
    checkOutput("sw dm_req c3", 32'(dm_req), 32'h1);
    tick(); dm_ack = 1'b0; bubble(); #1;
    checkOutput("sw wb_regwrite", 32'(wb_regwrite), 32'h0);
    checkOutput("sw next captured", mem_fwd_data, 32'h55);
    tick();
    checkOutput("post-sw wb_regwrite", 32'(wb_regwrite), 32'h1);
    checkOutput("post-sw wb_wraddr", 32'(wb_wraddr), 32'd11);
    checkOutput("post-sw wb_data", wb_data, 32'h55);

    // Timeout: no ack for TMO BUSY cycles
    applyStimulus(1'b1, 32'h300, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); bubble(); #1;
    checkOutput("tmo stall c1", 32'(stall_req), 32'h1);
    tick(); tick(); tick();
    checkOutput("tmo stall c4", 32'(stall_req), 32'h0);
    checkOutput("tmo dm_req c4", 32'(dm_req), 32'h1);
    tick();
    checkOutput("tmo dm_req drop", 32'(dm_req), 32'h0);
    checkOutput("tmo bus_err", 32'(bus_err), 32'h1);
    checkOutput("tmo wb_regwrite", 32'(wb_regwrite), 32'h0);
    tick();
    checkOutput("tmo bus_err once", 32'(bus_err), 32'h0);

    // Misaligned lw
    applyStimulus(1'b1, 32'h102, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); bubble(); #1;
    checkOutput("mis misalign", 32'(misalign), 32'h1);
    checkOutput("mis dm_req", 32'(dm_req), 32'h0);
    checkOutput("mis stall_req", 32'(stall_req), 32'h0);
    tick();
    checkOutput("mis pulse end", 32'(misalign), 32'h0);
    checkOutput("mis wb_regwrite", 32'(wb_regwrite), 32'h0);

    // ALU op followed by lw, then async reset while BUSY
    applyStimulus(1'b1, 32'h77, 32'h0, 5'd14, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); applyStimulus(1'b1, 32'h400, 32'h0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); bubble(); #1;
    checkOutput("rstb wb_regwrite", 32'(wb_regwrite), 32'h1);
    checkOutput("rstb dm_req", 32'(dm_req), 32'h1);
    checkOutput("rstb stall_req", 32'(stall_req), 32'h1);
    rst = 1'b1; #1;
    checkOutput("rst dm_req", 32'(dm_req), 32'h0);
    checkOutput("rst stall_req", 32'(stall_req), 32'h0);
    checkOutput("rst wb_regwrite", 32'(wb_regwrite), 32'h0);
    tick(); rst = 1'b0;
    applyStimulus(1'b1, 32'h99, 32'h0, 5'd16, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); bubble();
    tick();
    checkOutput("post-rst wb_regwrite", 32'(wb_regwrite), 32'h1);
    checkOutput("post-rst wb_wraddr", 32'(wb_wraddr), 32'd16);
    checkOutput("post-rst wb_data", wb_data, 32'h99);

    tick(); tick();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
- Combined EX/MEM pipeline register, load/store unit and MEM/WB pipeline register for the 5-stage MIPS pipeline.
- Consumes the ALU result and control bits produced by EX, and performs lw/sw over a req/ack data-memory bus.
- Produces the write-back fields for the RF, plus MEM-stage forwarding info for FWDPU and a stall request for HZDPU.
- Handles variable-latency memory, misaligned addresses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without dm_ack before the access is aborted (range 1..65535).
- ADDR_W, 32: data-memory byte address width.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ex_valid  input  1  EX holds a real instruction (not a bubble).
- ex_alu_res  input  32  ALU result; the byte address for lw/sw.
- ex_wdata  input  32  rt data for sw, already forwarded.
- ex_wraddr  input  5  destination register.
- ex_memread  input  1  lw.
- ex_memwrite  input  1  sw.
- ex_memtoreg  input  1  write-back source is load data.
- ex_regwrite  input  1  instruction writes the RF.
- stall_req  output  1  to HZDPU; freezes PC, IF/ID and ID/EX.
- dm_req  output  1  data-memory request.
- dm_we  output  1  1 = write.
- dm_addr  output  ADDR_W  word-aligned address.
- dm_wdata  output  32  store data.
- dm_ack  input  1  access complete this cycle.
- dm_rdata  input  32  load data, valid when dm_ack=1.
- mem_regwrite  output  1  MEM-stage regwrite for FWDPU (valid-qualified).
- mem_wraddr  output  5  MEM-stage destination.
- mem_memread  output  1  MEM-stage lw for FWDPU load-use detection.
- mem_fwd_data  output  32  MEM-stage ALU result for forwarding.
- wb_regwrite  output  1  RF write enable.
- wb_wraddr  output  5  RF write address.
- wb_data  output  32  RF write data.
- misalign  output  1  one-cycle pulse: lw/sw with addr[1:0]!=0.
- bus_err  output  1  one-cycle pulse: access aborted by timeout.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, timeout counter 0, MEM and WB valid bits 0. Reset asserted mid-access drops dm_req immediately; the access is abandoned.
- EX/MEM register loads all ex_* fields on every rising edge where stall_req=0; it holds when stall_req=1.
- FSM states:
  - IDLE: at the capture edge, if the captured instruction is valid, (memread|memwrite) and addr[1:0]==0, then next state BUSY; at that same edge register dm_req=1, dm_we=memwrite, dm_addr={addr[31:2],2'b00}, dm_wdata.
  - BUSY, dm_ack=1: dm_req<=0; next state IDLE; the result is retired to WB at this edge.
  - BUSY, counter==TIMEOUT_CYCLES-1 and dm_ack=0: dm_req<=0; next state IDLE; bus_err pulses; WB receives a bubble (wb_regwrite=0).
- stall_req = (state==BUSY) & ~dm_ack & ~timeout_hit. It is combinational, so an ack in the first BUSY cycle costs zero stall cycles.
- Timeout counter: cleared on entry to BUSY, increments each BUSY cycle. Ack and timeout in the same cycle: ack wins.
- dm_req, dm_we, dm_addr and dm_wdata are stable while BUSY.
- Misaligned lw/sw: no bus request; misalign pulses the cycle after capture; the instruction retires as a bubble.
- Non-memory instructions spend exactly one cycle in MEM.
- WB register, at each edge where MEM retires:
  - wb_regwrite = valid & regwrite & ~abort.
  - wb_wraddr = wraddr.
  - wb_data = memtoreg ? dm_rdata : alu_res.
  - When MEM does not retire (stall), WB loads a bubble with wb_regwrite=0, so the RF is written exactly once per instruction.
- Forwarding outputs are combinational from the EX/MEM register, each qualified by the MEM valid bit:
  - mem_regwrite = valid & regwrite & ~memread.
  - mem_memread = valid & memread.
  - mem_fwd_data = alu_res.
- sw never writes the RF, even if ex_regwrite=1 arrives with it.
- wraddr=0 is passed through unchanged; RF ignores writes to $0.

Test Plan:
- ALU op: add result 0x0000_0010 to $8 with regwrite -> wb_regwrite=1, wb_wraddr=8, wb_data=0x10 two edges after ex_valid; stall_req never asserts.
- lw, zero-wait: addr 0x100, dm_ack=1 in the first BUSY cycle with dm_rdata=0xDEADBEEF -> stall_req stays 0; the next edge gives wb_data=0xDEADBEEF and wb_wraddr matches.
- sw with 3-cycle ack: addr 0x204, data 0x12345678 -> dm_req=1, dm_we=1, dm_addr=0x204 held for 3 cycles; stall_req=1 for 2 cycles; EX/MEM inputs are ignored while stalled; wb_regwrite=0.
- Timeout: TIMEOUT_CYCLES=4, lw with dm_ack held 0 -> dm_req drops after 4 BUSY cycles; bus_err pulses once; wb_regwrite=0; the pipeline resumes.
- Misaligned: lw to addr 0x102 -> dm_req stays 0; misalign pulses for 1 cycle; no RF write.
- Async reset while BUSY: assert rst between edges -> dm_req, stall_req and wb_regwrite go 0 immediately. After release, an ALU op proceeds normally.
